// File: rtl/freorder.sv
// freorder: output-side reorder buffer for the FFT/IFFT chain.
//
// Takes the address-tagged sample stream from the last butterfly stage,
// writes each sample into a ping-pong RAM at bitrev(iaddr) (or iaddr when
// BIT_REVERSE = 0), and reads every completed frame back out in natural order
// with a regenerated index tag.
//
// Ports:
//   iclk   in   clock, rising edge
//   irst   in   synchronous active-high reset
//   ien    in   input sample valid
//   idata  in   {real, imag} input sample
//   iaddr  in   sample index within the frame, as tagged upstream
//   oen    out  output sample valid
//   odata  out  reordered {real, imag} sample
//   oaddr  out  natural-order index of odata
//   ofirst out  high with oen when oaddr == 0
//   oerr   out  sticky overflow flag, cleared only by irst
//
// Reader states:
//   state  | meaning
//   S_IDLE | no full bank to drain; issues address 0 as soon as one fills
//   S_READ | issuing one RAM read per cycle from rd_bank at cnt
module freorder #(
  parameter int REAL_WIDTH  = 18,
  parameter int IMGN_WIDTH  = 18,
  parameter int TOTAL_STAGE = 11,
  parameter int BIT_REVERSE = 1
) (
  input  logic                                iclk,
  input  logic                                irst,
  input  logic                                ien,
  input  logic [REAL_WIDTH+IMGN_WIDTH-1:0]    idata,
  input  logic [TOTAL_STAGE-1:0]              iaddr,
  output logic                                oen,
  output logic [REAL_WIDTH+IMGN_WIDTH-1:0]    odata,
  output logic [TOTAL_STAGE-1:0]              oaddr,
  output logic                                ofirst,
  output logic                                oerr
);

  localparam int CPLX_WIDTH = REAL_WIDTH + IMGN_WIDTH;
  localparam int N          = 1 << TOTAL_STAGE;
  localparam logic [TOTAL_STAGE-1:0] LAST = '1;

  typedef enum logic {S_IDLE, S_READ} state_t;

  function automatic logic [TOTAL_STAGE-1:0] bitrev(input logic [TOTAL_STAGE-1:0] a);
    logic [TOTAL_STAGE-1:0] r;
    for (int i = 0; i < TOTAL_STAGE; i++) r[i] = a[TOTAL_STAGE-1-i];
    return r;
  endfunction

  logic [CPLX_WIDTH-1:0]  mem [0:2*N-1];
  logic [CPLX_WIDTH-1:0]  ram_q;

  state_t                 state, state_nxt;
  logic [TOTAL_STAGE-1:0] cnt, cnt_nxt;
  logic [1:0]             full, full_nxt;
  logic                   wr_bank, rd_bank, other_bank;
  logic [TOTAL_STAGE-1:0] wa;
  logic                   wr_ok, wr_done;
  logic                   rd_go, rd_last;
  logic                   v1;
  logic [TOTAL_STAGE-1:0] a1;

  assign other_bank = ~rd_bank;
  assign wa         = (BIT_REVERSE != 0) ? bitrev(iaddr) : iaddr;
  // Writes are suppressed during reset so a discarded frame never lands in RAM.
  assign wr_ok      = ien & ~full[wr_bank] & ~irst;
  assign wr_done    = wr_ok & (iaddr == LAST);

  // Reader: in IDLE the read of address 0 is issued in the same cycle a full
  // bank becomes visible, which gives the 3-cycle input-to-output latency.
  always_comb begin
    rd_go     = 1'b0;
    rd_last   = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:  rd_go = full[rd_bank];
      S_READ:  rd_go = 1'b1;
      default: rd_go = 1'b0;
    endcase
    if (rd_go) begin
      if (cnt == LAST) begin
        rd_last = 1'b1;
        cnt_nxt = '0;
        // Continue without a bubble if the other bank is full or filling now.
        if (full[other_bank] || (wr_done && (wr_bank == other_bank)))
          state_nxt = S_READ;
        else
          state_nxt = S_IDLE;
      end else begin
        cnt_nxt   = cnt + TOTAL_STAGE'(1);
        state_nxt = S_READ;
      end
    end
  end

  // Release and fill never target the same bank: fill needs full == 0,
  // release needs full == 1.
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      v1      <= 1'b0;
      a1      <= '0;
      oen     <= 1'b0;
      odata   <= '0;
      oaddr   <= '0;
      ofirst  <= 1'b0;
      oerr    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      full  <= full_nxt;
      if (wr_done) wr_bank <= ~wr_bank;
      if (rd_last) rd_bank <= ~rd_bank;
      // A bank being released this cycle still counts as full for the writer.
      if (ien && full[wr_bank]) oerr <= 1'b1;
      v1     <= rd_go;
      a1     <= cnt;
      oen    <= v1;
      ofirst <= v1 && (a1 == '0);
      if (v1) begin
        odata <= ram_q;
        oaddr <= a1;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_ok) mem[{wr_bank, wa}] <= idata;
    if (rd_go) ram_q <= mem[{rd_bank, cnt}];
  end

endmodule
